// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the MIPS datapath and memories.
// The sequencer takes the slave view; the datapath (or a bench) takes the master view.
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       OPcode;
  logic [5:0]       funct;
  logic             ALUZero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             MemtoReg;
  logic             MemWrite;
  logic             PCSrc;
  logic             ALUSrc;
  logic             RegDst;
  logic             RegWrite;
  logic             SgnZero;
  logic [2:0]       ALUOP;
  logic             PCEn;
  logic             IRWrite;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  OPcode, funct, ALUZero, imem_ready, dmem_ready,
    output MemtoReg, MemWrite, PCSrc, ALUSrc, RegDst, RegWrite, SgnZero,
           ALUOP, PCEn, IRWrite, illegal, retired
  );

  modport master (
    output OPcode, funct, ALUZero, imem_ready, dmem_ready,
    input  MemtoReg, MemWrite, PCSrc, ALUSrc, RegDst, RegWrite, SgnZero,
           ALUOP, PCEn, IRWrite, illegal, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: decode, control strobes, PC/IR gating, retire count, traps.
//   state    | meaning
//   S_FETCH  | wait for instruction word, latch it on imem_ready
//   S_DECODE | classify opcode/funct, trap if unknown
//   S_EXEC   | ALU operation; BEQ resolves and retires here
//   S_MEM    | data access; SW retires on dmem_ready
//   S_WB     | register write-back and retire
//   S_ERR    | sticky trap, left only through reset
module mips_multicycle_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input logic                   clk,
  input logic                   reset,
  mips_multicycle_ctrl_if.slave bus
);
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR} state_t;
  typedef enum logic [2:0] {C_RTYPE, C_LW, C_SW, C_BEQ, C_ADDI, C_ANDI, C_ORI, C_BAD} cls_t;

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d, dec_cls;
  logic [2:0]        rop_q, rop_d, dec_rop;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic mem_to_reg, mem_write, pc_src, alu_src, reg_dst, reg_write, sgn_zero;
  logic pc_en, ir_write;
  logic [2:0] alu_op;

  always_comb begin
    dec_cls = C_BAD;
    dec_rop = OP_ADD;
    case (bus.OPcode)
      6'b000000: begin
        dec_cls = C_RTYPE;
        case (bus.funct)
          6'b100000: dec_rop = OP_ADD;
          6'b100010: dec_rop = OP_SUB;
          6'b100100: dec_rop = OP_AND;
          6'b100101: dec_rop = OP_OR;
          6'b101010: dec_rop = OP_SLT;
          default:   dec_cls = C_BAD;
        endcase
      end
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: dec_cls = C_BEQ;
      6'b001000: dec_cls = C_ADDI;
      6'b001100: dec_cls = C_ANDI;
      6'b001101: dec_cls = C_ORI;
      default:   dec_cls = C_BAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_BAD;
      rop_q     <= OP_ADD;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      rop_q     <= rop_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Class and R-type ALU op are captured once in DECODE so later states ignore IR churn.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    rop_d   = rop_q;
    wait_d  = wait_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ready)        state_d = S_DECODE;
        else if (wait_q == WAIT_LAST) state_d = S_ERR;
        else                       wait_d  = wait_q + 1'b1;
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        rop_d   = dec_rop;
        state_d = (dec_cls == C_BAD) ? S_ERR : S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ:      state_d = S_FETCH;
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready)        state_d = (cls_q == C_SW) ? S_FETCH : S_WB;
        else if (wait_q == WAIT_LAST) state_d = S_ERR;
        else                       wait_d  = wait_q + 1'b1;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_ERR;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  always_comb begin
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    sgn_zero   = 1'b0;
    alu_op     = 3'b000;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    case (state_q)
      // Gated by reset so the IR cannot be loaded while the sequencer is held.
      S_FETCH: ir_write = bus.imem_ready & reset;
      S_EXEC, S_MEM, S_WB: begin
        alu_src  = cls_q inside {C_LW, C_SW, C_ADDI, C_ANDI, C_ORI};
        sgn_zero = cls_q inside {C_ANDI, C_ORI};
        case (cls_q)
          C_RTYPE: alu_op = rop_q;
          C_ANDI:  alu_op = OP_AND;
          C_ORI:   alu_op = OP_OR;
          C_BEQ:   alu_op = OP_SUB;
          default: alu_op = OP_ADD;
        endcase
        if (state_q == S_EXEC && cls_q == C_BEQ) begin
          pc_src = bus.ALUZero;
          pc_en  = 1'b1;
        end
        if (state_q == S_MEM) begin
          mem_write = (cls_q == C_SW);
          pc_en     = (cls_q == C_SW) & bus.dmem_ready;
        end
        if (state_q == S_WB) begin
          reg_write  = 1'b1;
          pc_en      = 1'b1;
          reg_dst    = (cls_q == C_RTYPE);
          mem_to_reg = (cls_q == C_LW);
        end
      end
      default: ;
    endcase
  end

  assign retired_d = pc_en ? retired_q + 1'b1 : retired_q;

  assign bus.MemtoReg = mem_to_reg;
  assign bus.MemWrite = mem_write;
  assign bus.PCSrc    = pc_src;
  assign bus.ALUSrc   = alu_src;
  assign bus.RegDst   = reg_dst;
  assign bus.RegWrite = reg_write;
  assign bus.SgnZero  = sgn_zero;
  assign bus.ALUOP    = alu_op;
  assign bus.PCEn     = pc_en;
  assign bus.IRWrite  = ir_write;
  assign bus.illegal  = (state_q == S_ERR);
  assign bus.retired  = retired_q;
endmodule
